// File: rtl/exe_module_pkg.sv
// Shared constants for the execute stage: ALU commands, shift types,
// NZCV bit positions and forwarding-select codes.
package exe_module_pkg;

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [3:0] CMD_MVN = 4'b1001;

   localparam logic [1:0] SHIFT_LSL = 2'b00;
   localparam logic [1:0] SHIFT_LSR = 2'b01;
   localparam logic [1:0] SHIFT_ASR = 2'b10;
   localparam logic [1:0] SHIFT_ROR = 2'b11;

   localparam int N_BIT = 3;
   localparam int Z_BIT = 2;
   localparam int C_BIT = 1;
   localparam int V_BIT = 0;

   localparam logic [1:0] FWD_ID  = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

   // Rotate right; a shift of 32 on a 32-bit value yields 0, so amt=0 is a pass-through.
   function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
      return (v >> amt) | (v << (6'd32 - {1'b0, amt}));
   endfunction

endpackage

// File: rtl/exe_module_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled as one bus.
interface exe_module_if;
   logic        wb_enable_in, mem_read_in, mem_write_in, branch_enable_in, S_in, immidiate_in;
   logic [3:0]  exec_cmd_in;
   logic [31:0] PC_in;
   logic [31:0] Val_Rn_in, Val_Rm_in;
   logic [11:0] Shift_operand_in;
   logic [23:0] Signed_immidiate_24_in;
   logic [3:0]  Dest_in;
   logic [1:0]  sel_src1, sel_src2;
   logic [31:0] mem_fwd_value, wb_fwd_value;
   logic        branch_taken;
   logic [31:0] branch_address;
   logic [3:0]  status;
   logic        wb_enable_out, mem_read_out, mem_write_out;
   logic [31:0] ALU_result, Store_value;
   logic [3:0]  Dest_out;

   modport master (
      output wb_enable_in, mem_read_in, mem_write_in, branch_enable_in, S_in, immidiate_in,
             exec_cmd_in, PC_in, Val_Rn_in, Val_Rm_in, Shift_operand_in,
             Signed_immidiate_24_in, Dest_in, sel_src1, sel_src2, mem_fwd_value, wb_fwd_value,
      input  branch_taken, branch_address, status, wb_enable_out, mem_read_out,
             mem_write_out, ALU_result, Store_value, Dest_out
   );

   modport slave (
      input  wb_enable_in, mem_read_in, mem_write_in, branch_enable_in, S_in, immidiate_in,
             exec_cmd_in, PC_in, Val_Rn_in, Val_Rm_in, Shift_operand_in,
             Signed_immidiate_24_in, Dest_in, sel_src1, sel_src2, mem_fwd_value, wb_fwd_value,
      output branch_taken, branch_address, status, wb_enable_out, mem_read_out,
             mem_write_out, ALU_result, Store_value, Dest_out
   );
endinterface

// File: rtl/exe_module_alu.sv
// Combinational ALU: result and next NZCV from op1, Val2, command and current C/V.
module exe_alu
   import exe_module_pkg::*;
(
   input  logic [31:0] op1,
   input  logic [31:0] val2,
   input  logic [3:0]  cmd,
   input  logic        c_in,
   input  logic        v_in,
   output logic [31:0] result,
   output logic [3:0]  nzcv
);

   logic [32:0] sum;
   logic        c_out, v_out;

   always_comb begin
      sum    = 33'd0;
      result = 32'd0;
      c_out  = c_in;
      v_out  = v_in;
      case (cmd)
         CMD_MOV: result = val2;
         CMD_MVN: result = ~val2;
         CMD_ADD, CMD_ADC: begin
            sum    = {1'b0, op1} + {1'b0, val2} + {32'd0, (cmd == CMD_ADC) & c_in};
            result = sum[31:0];
            c_out  = sum[32];
            v_out  = (op1[31] == val2[31]) && (result[31] != op1[31]);
         end
         // Subtract as op1 + ~val2 + carry so the carry-out is ARM's "no borrow".
         CMD_SUB, CMD_SBC: begin
            sum    = {1'b0, op1} + {1'b0, ~val2} + {32'd0, (cmd == CMD_SUB) | c_in};
            result = sum[31:0];
            c_out  = sum[32];
            v_out  = (op1[31] != val2[31]) && (result[31] != op1[31]);
         end
         CMD_AND: result = op1 & val2;
         CMD_ORR: result = op1 | val2;
         CMD_EOR: result = op1 ^ val2;
         default: result = 32'd0;
      endcase
      nzcv = {result[31], (result == 32'd0), c_out, v_out};
   end

endmodule

// File: rtl/exe_module.sv
// Execute stage: operand forwarding, Val2 generation, ALU, branch target,
// NZCV status register and the EX/MEM pipeline register.
module exe_module
   import exe_module_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         freeze,
   exe_module_if.slave  bus
);

   logic [31:0] op1, rm_f, val2, alu_result;
   logic [3:0]  alu_nzcv;
   logic [4:0]  shift_amt;

   logic [3:0]  status_q, status_d;
   logic        wb_enable_q, wb_enable_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic [31:0] alu_result_q, alu_result_d;
   logic [31:0] store_value_q, store_value_d;
   logic [3:0]  dest_q, dest_d;

   always_comb begin
      case (bus.sel_src1)
         FWD_MEM: op1 = bus.mem_fwd_value;
         FWD_WB:  op1 = bus.wb_fwd_value;
         default: op1 = bus.Val_Rn_in;
      endcase
      case (bus.sel_src2)
         FWD_MEM: rm_f = bus.mem_fwd_value;
         FWD_WB:  rm_f = bus.wb_fwd_value;
         default: rm_f = bus.Val_Rm_in;
      endcase
   end

   assign shift_amt = bus.Shift_operand_in[11:7];

   // Immediate beats the load/store offset, which beats the register shifter.
   always_comb begin
      val2 = rm_f;
      if (bus.immidiate_in) begin
         val2 = ror32({24'd0, bus.Shift_operand_in[7:0]}, {bus.Shift_operand_in[11:8], 1'b0});
      end else if (bus.mem_read_in || bus.mem_write_in) begin
         val2 = {20'd0, bus.Shift_operand_in};
      end else begin
         case (bus.Shift_operand_in[6:5])
            SHIFT_LSL: val2 = rm_f << shift_amt;
            SHIFT_LSR: val2 = rm_f >> shift_amt;
            SHIFT_ASR: val2 = $unsigned($signed(rm_f) >>> shift_amt);
            default:   val2 = ror32(rm_f, shift_amt);
         endcase
      end
   end

   exe_alu u_alu (
      .op1    (op1),
      .val2   (val2),
      .cmd    (bus.exec_cmd_in),
      .c_in   (status_q[C_BIT]),
      .v_in   (status_q[V_BIT]),
      .result (alu_result),
      .nzcv   (alu_nzcv)
   );

   assign bus.branch_taken   = bus.branch_enable_in;
   assign bus.branch_address = bus.PC_in + {{6{bus.Signed_immidiate_24_in[23]}},
                                            bus.Signed_immidiate_24_in, 2'b00};

   always_comb begin
      status_d      = bus.S_in ? alu_nzcv : status_q;
      wb_enable_d   = bus.wb_enable_in;
      mem_read_d    = bus.mem_read_in;
      mem_write_d   = bus.mem_write_in;
      alu_result_d  = alu_result;
      store_value_d = rm_f;
      dest_d        = bus.Dest_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         status_q      <= 4'd0;
         wb_enable_q   <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         alu_result_q  <= 32'd0;
         store_value_q <= 32'd0;
         dest_q        <= 4'd0;
      end else if (!freeze) begin
         status_q      <= status_d;
         wb_enable_q   <= wb_enable_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
         alu_result_q  <= alu_result_d;
         store_value_q <= store_value_d;
         dest_q        <= dest_d;
      end
   end

   assign bus.status        = status_q;
   assign bus.wb_enable_out = wb_enable_q;
   assign bus.mem_read_out  = mem_read_q;
   assign bus.mem_write_out = mem_write_q;
   assign bus.ALU_result    = alu_result_q;
   assign bus.Store_value   = store_value_q;
   assign bus.Dest_out      = dest_q;

endmodule
